// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, jump/branch flush sequencing and a
// saturating bubble-cycle counter. State advances on the falling clock edge.
module hazard_ctrl_unit #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 Reset_L,
  input  logic [4:0]           ID_Rs,
  input  logic [4:0]           ID_Rt,
  input  logic                 ID_UsesRs,
  input  logic                 ID_UsesRt,
  input  logic [4:0]           EX_Rt,
  input  logic                 EX_MemRead,
  input  logic                 Jump,
  input  logic                 Branch,
  input  logic                 BranchTaken,
  output logic                 PCWrite,
  output logic                 IFWrite,
  output logic                 Bubble,
  output logic [1:0]           AddrSel,
  output logic [CNT_WIDTH-1:0] BubbleCount
);

  typedef enum logic [1:0] {StNoHaz, StJump, StBranch0, StBranch1} state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic                 w_load_use;
  logic [CNT_WIDTH-1:0] r_bubble_cnt;

  assign w_load_use = EX_MemRead && (EX_Rt != 5'd0) &&
                      ((ID_UsesRs && (ID_Rs == EX_Rt)) || (ID_UsesRt && (ID_Rt == EX_Rt)));

  always_ff @(negedge clk or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state <= StNoHaz;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StNoHaz: begin
        if (w_load_use)  w_state_next = StNoHaz;
        else if (Jump)   w_state_next = StJump;
        else if (Branch) w_state_next = StBranch0;
      end
      StJump:    w_state_next = StNoHaz;
      StBranch0: w_state_next = BranchTaken ? StBranch1 : StNoHaz;
      StBranch1: w_state_next = StNoHaz;
      default:   w_state_next = StNoHaz;
    endcase
  end

  always_comb begin
    PCWrite = 1'b1;
    IFWrite = 1'b1;
    Bubble  = 1'b0;
    AddrSel = 2'b00;
    if (!Reset_L) begin
      PCWrite = 1'b0;
      IFWrite = 1'b0;
      Bubble  = 1'b1;
    end else begin
      unique case (r_state)
        StNoHaz: begin
          if (w_load_use) begin
            PCWrite = 1'b0;
            IFWrite = 1'b0;
            Bubble  = 1'b1;
          end else if (Jump) begin
            IFWrite = 1'b0;
            AddrSel = 2'b01;
          end else if (Branch) begin
            // Hold fetch until the branch resolves in EX.
            PCWrite = 1'b0;
            IFWrite = 1'b0;
          end
        end
        StJump: Bubble = 1'b1;
        StBranch0: begin
          Bubble = 1'b1;
          if (BranchTaken) begin
            IFWrite = 1'b0;
            AddrSel = 2'b10;
          end
        end
        StBranch1: Bubble = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(negedge clk or negedge Reset_L) begin
    if (!Reset_L) begin
      r_bubble_cnt <= '0;
    end else if (Bubble && (r_bubble_cnt != {CNT_WIDTH{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign BubbleCount = r_bubble_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit; a narrow-counter copy checks
// saturation alongside the default-width instance.
module tb_hazard_ctrl_unit;

  logic        clk;
  logic        Reset_L;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rt;
  logic        ID_UsesRs, ID_UsesRt, EX_MemRead, Jump, Branch, BranchTaken;
  logic        PCWrite, IFWrite, Bubble;
  logic [1:0]  AddrSel;
  logic [15:0] BubbleCount;
  logic        s_PCWrite, s_IFWrite, s_Bubble;
  logic [1:0]  s_AddrSel;
  logic [3:0]  s_BubbleCount;

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl_unit #(.CNT_WIDTH(16)) u_dut (
    .clk(clk), .Reset_L(Reset_L), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .EX_Rt(EX_Rt), .EX_MemRead(EX_MemRead),
    .Jump(Jump), .Branch(Branch), .BranchTaken(BranchTaken),
    .PCWrite(PCWrite), .IFWrite(IFWrite), .Bubble(Bubble), .AddrSel(AddrSel),
    .BubbleCount(BubbleCount)
  );

  hazard_ctrl_unit #(.CNT_WIDTH(4)) u_sat (
    .clk(clk), .Reset_L(Reset_L), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .EX_Rt(EX_Rt), .EX_MemRead(EX_MemRead),
    .Jump(Jump), .Branch(Branch), .BranchTaken(BranchTaken),
    .PCWrite(s_PCWrite), .IFWrite(s_IFWrite), .Bubble(s_Bubble), .AddrSel(s_AddrSel),
    .BubbleCount(s_BubbleCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs packed as {PCWrite, IFWrite, Bubble, AddrSel}.
  task automatic chk_out(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, PCWrite, IFWrite, Bubble, AddrSel}, {27'd0, exp});
  endtask

  task automatic mid();
    @(posedge clk);
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_in();
    ID_Rs = 0; ID_Rt = 0; EX_Rt = 0; ID_UsesRs = 0; ID_UsesRt = 0;
    EX_MemRead = 0; Jump = 0; Branch = 0; BranchTaken = 0;
  endtask

  initial begin
    Reset_L = 1'b0;
    clear_in();

    for (int i = 0; i < 3; i++) begin
      mid();
      chk_out("reset_out", 5'b00100);
      chk("reset_cnt", 32'(BubbleCount), 32'd0);
      cyc();
    end
    Reset_L = 1'b1;
    mid(); chk_out("post_reset", 5'b11000); cyc();
    chk("post_reset_cnt", 32'(BubbleCount), 32'd0);

    // Load-use via rs
    EX_MemRead = 1; EX_Rt = 5; ID_Rs = 5; ID_UsesRs = 1;
    mid(); chk_out("lu_rs", 5'b00100); cyc();
    chk("lu_rs_cnt", 32'(BubbleCount), 32'd1);
    // Register zero never stalls
    EX_Rt = 0; ID_Rs = 0;
    mid(); chk_out("lu_r0", 5'b11000); cyc();
    // rs matches but is not read
    EX_Rt = 5; ID_Rs = 5; ID_UsesRs = 0; ID_Rt = 5; ID_UsesRt = 0;
    mid(); chk_out("lu_unused", 5'b11000); cyc();
    chk("lu_unused_cnt", 32'(BubbleCount), 32'd1);
    // Load-use via rt
    ID_Rs = 7; ID_UsesRs = 1; ID_UsesRt = 1;
    mid(); chk_out("lu_rt", 5'b00100); cyc();
    chk("lu_rt_cnt", 32'(BubbleCount), 32'd2);
    clear_in();

    // Jump, held high into JUMP to show it is ignored there
    Jump = 1;
    mid(); chk_out("jmp_c1", 5'b10001); cyc();
    mid(); chk_out("jmp_c2", 5'b11100); cyc();
    Jump = 0;
    chk("jmp_cnt", 32'(BubbleCount), 32'd3);
    mid(); chk_out("jmp_c3", 5'b11000); cyc();

    // Branch taken
    Branch = 1;
    mid(); chk_out("bt_c1", 5'b00000); cyc();
    Branch = 0; BranchTaken = 1;
    mid(); chk_out("bt_c2", 5'b10110); cyc();
    mid(); chk_out("bt_c3", 5'b11100); cyc();
    BranchTaken = 0;
    chk("bt_cnt", 32'(BubbleCount), 32'd5);
    mid(); chk_out("bt_c4", 5'b11000); cyc();

    // Branch not taken
    Branch = 1;
    mid(); chk_out("bn_c1", 5'b00000); cyc();
    Branch = 0;
    mid(); chk_out("bn_c2", 5'b11100); cyc();
    chk("bn_cnt", 32'(BubbleCount), 32'd6);
    mid(); chk_out("bn_c3", 5'b11000); cyc();

    // Priority: load-use over jump over branch
    EX_MemRead = 1; EX_Rt = 9; ID_Rt = 9; ID_UsesRt = 1; Jump = 1; Branch = 1;
    mid(); chk_out("pri_lu", 5'b00100); cyc();
    EX_MemRead = 0;
    mid(); chk_out("pri_jmp", 5'b10001); cyc();
    Jump = 0; Branch = 0;
    mid(); chk_out("pri_jmp_c2", 5'b11100); cyc();
    chk("pri_cnt", 32'(BubbleCount), 32'd8);
    clear_in();

    // Asynchronous reset while in BRANCH0
    Branch = 1;
    mid(); cyc();
    Branch = 0; BranchTaken = 1;
    #1 Reset_L = 1'b0;
    #1;
    chk_out("rst_b0_out", 5'b00100);
    chk("rst_b0_cnt", 32'(BubbleCount), 32'd0);
    Reset_L = 1'b1;
    mid(); chk_out("rst_b0_nohaz", 5'b11000); cyc();
    chk("rst_b0_cnt2", 32'(BubbleCount), 32'd0);
    BranchTaken = 0;

    // Saturation on the 4-bit instance
    EX_MemRead = 1; EX_Rt = 3; ID_Rs = 3; ID_UsesRs = 1;
    for (int i = 1; i <= 20; i++) begin
      mid(); cyc();
      chk("sat_cnt", 32'(s_BubbleCount), (i < 15) ? i : 15);
    end
    chk("wide_cnt", 32'(BubbleCount), 32'd20);
    clear_in();
    mid(); chk_out("final_out", 5'b11000); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Generates the pipeline control signals consumed by the IF/ID register, the PC and the ID/EX register: PCWrite, IFWrite, Bubble and the next-PC select.
- Detects load-use hazards between the instruction in ID and a load in EX, and sequences the stalls and flushes for jumps (resolved in ID) and branches (resolved in EX).
- Keeps a saturating count of bubble cycles for performance analysis.
- Sits in the ID stage beside the control and forwarding units.

Parameters:
CNT_WIDTH, 16, width of the bubble-cycle counter.

Ports:
clk  input  1  pipeline clock; state updates on the falling edge, matching the pipeline registers.
Reset_L  input  1  asynchronous, active-low reset.
ID_Rs  input  5  rs field of the instruction in ID.
ID_Rt  input  5  rt field of the instruction in ID.
ID_UsesRs  input  1  the ID instruction reads rs.
ID_UsesRt  input  1  the ID instruction reads rt.
EX_Rt  input  5  destination rt of the instruction in EX (IM_20_0_ID_EX[20:16]).
EX_MemRead  input  1  the instruction in EX is a load.
Jump  input  1  the ID instruction is a jump.
Branch  input  1  the ID instruction is a conditional branch.
BranchTaken  input  1  branch outcome; valid only while the branch is in EX (state BRANCH0).
PCWrite  output  1  PC load enable.
IFWrite  output  1  IF/ID register load enable.
Bubble  output  1  to the ID/EX register; zeroes the ID/EX control signals.
AddrSel  output  2  next-PC select: 00 = PC+4, 01 = jump target, 10 = branch target, 11 = unused.
BubbleCount  output  CNT_WIDTH  number of cycles in which Bubble was 1, saturating.

Behaviour:
- States: NOHAZ, JUMP, BRANCH0, BRANCH1. The state register is clocked on negedge clk.
- Outputs are combinational from the state and inputs (Mealy).
- Reset, while Reset_L=0 (asynchronous):
  - state=NOHAZ, BubbleCount=0.
  - Outputs forced to PCWrite=0, IFWrite=0, Bubble=1, AddrSel=00.
- Reset mid-sequence (any state) aborts to NOHAZ immediately. No pending branch or jump survives reset.
- LoadUse = EX_MemRead & (EX_Rt!=0) & ((ID_UsesRs & ID_Rs==EX_Rt) | (ID_UsesRt & ID_Rt==EX_Rt)).
- NOHAZ, priority LoadUse > Jump > Branch:
  - LoadUse: PCWrite=0, IFWrite=0, Bubble=1, AddrSel=00; next NOHAZ. Re-evaluated each cycle, so a single load gives exactly one bubble.
  - Jump: PCWrite=1, IFWrite=0, Bubble=0, AddrSel=01; next JUMP.
  - Branch: PCWrite=0, IFWrite=0, Bubble=0, AddrSel=00; next BRANCH0.
  - Otherwise: PCWrite=1, IFWrite=1, Bubble=0, AddrSel=00; stay in NOHAZ.
- JUMP: PCWrite=1, IFWrite=1, Bubble=1 (squashes the held duplicate jump), AddrSel=00; next NOHAZ.
- BRANCH0 (branch is in EX):
  - BranchTaken=1: PCWrite=1, IFWrite=0, Bubble=1, AddrSel=10; next BRANCH1.
  - BranchTaken=0: PCWrite=1, IFWrite=1, Bubble=1, AddrSel=00; next NOHAZ.
- BRANCH1: PCWrite=1, IFWrite=1, Bubble=1, AddrSel=00; next NOHAZ.
- Input handling:
  - LoadUse, Jump and Branch are ignored outside NOHAZ.
  - Jump and Branch asserted together: Jump wins.
  - BranchTaken is ignored outside BRANCH0.
- Cost per event: jump = 1 bubble; branch not taken = 1 bubble; branch taken = 2 bubbles; load-use = 1 bubble per cycle in which LoadUse is true.
- BubbleCount: increments on each negedge where Bubble=1 and Reset_L=1. It holds at 2^CNT_WIDTH-1 and never wraps.
- AddrSel=11 is never produced.

Test Plan:
- Reset: hold Reset_L=0 for 3 cycles, then release with no hazard -> during reset PCWrite=0, IFWrite=0, Bubble=1, BubbleCount=0; after release PCWrite=1, IFWrite=1, Bubble=0, AddrSel=00.
- Load-use: EX_MemRead=1, EX_Rt=5, ID_Rs=5, ID_UsesRs=1 for one cycle -> that cycle PCWrite=0, IFWrite=0, Bubble=1, BubbleCount 0->1. Same stimulus with EX_Rt=0, or with ID_UsesRs=0 -> no stall.
- Jump: Jump=1 for one cycle -> cycle 1 AddrSel=01, IFWrite=0, Bubble=0; cycle 2 (JUMP) Bubble=1, IFWrite=1; cycle 3 back in NOHAZ; BubbleCount +1.
- Branch taken: Branch=1, then BranchTaken=1 in BRANCH0 -> cycle 1 PCWrite=0, IFWrite=0; cycle 2 AddrSel=10, Bubble=1; cycle 3 Bubble=1, IFWrite=1; BubbleCount +2. Branch not taken -> cycle 2 AddrSel=00, IFWrite=1, Bubble=1; BubbleCount +1.
- Priority and reset: LoadUse with Jump=1 and Branch=1 -> stall only, state stays NOHAZ; next cycle with LoadUse=0 -> jump sequence starts. Pulse Reset_L=0 while in BRANCH0 -> state NOHAZ, BubbleCount=0.
- Saturation: CNT_WIDTH=4, 20 consecutive load-use cycles -> BubbleCount reaches 15 and holds.
